idex_stage_reg: RTL and testbench
=================================

Name: idex_stage_reg

Overview:
- ID/EX pipeline register of the MIPS III pipeline.
- Captures decoded control and operand data from ID and drives the EX-stage signal set (ALUOp, Link, ALUSrcImm, Trap, TrapCond, RegDst, LLSC, Mem*, RegWrite, MemtoReg, Rd, Shamt, ReadData1/2, ExtImmOut).
- Detects load-use hazards against the instruction currently in EX, and inserts bubbles on hazard or flush.
- Holds its contents while EX is stalled, and keeps a bubble counter for performance monitoring.

Parameters:
- DW, 32, data path width (ReadData1/2, ExtImmOut, PC)
- CNTW, 32, bubble counter width

Ports:
- clock  in  1  pipeline clock
- reset  in  1  asynchronous, active-high reset
- Flush  in  1  kill the instruction entering EX (branch mispredict / exception)
- ExStall  in  1  EX busy (mul/div); hold register contents
- id_Valid  in  1  ID holds a real instruction
- id_Ctrl  in  ex_ctrl_t  decoded EX/MEM/WB control bundle
- id_Rs, id_Rt, id_Rd  in  5 each  register specifiers
- id_UsesRs, id_UsesRt  in  1 each  instruction reads that source
- id_Shamt  in  5  shift amount
- id_ReadData1, id_ReadData2, id_ExtImmOut, id_PC  in  DW each  operands, extended immediate, PC
- ex_Valid  out  1  EX holds a real instruction
- ex_Ctrl  out  ex_ctrl_t  registered control bundle
- ex_Rs, ex_Rt, ex_Rd, ex_Shamt  out  5 each  registered fields
- ex_ReadData1, ex_ReadData2, ex_ExtImmOut, ex_PC  out  DW each  registered data
- LoadUseStall  out  1  combinational: load-use hazard this cycle
- StallID  out  1  combinational: freeze PC and IF/ID (LoadUseStall | ExStall)
- BubbleCount  out  CNTW  number of bubbles inserted since reset

Behaviour:
- Reset (asynchronous): every output register goes to 0, including ex_Valid, ex_Ctrl, all fields, all data and BubbleCount. The first clock edge after reset deasserts performs a normal update.
- Hazard, combinational: LoadUseStall = ex_Valid & ex_Ctrl.MemRead & (ex_Rt != 0) & id_Valid & ((id_UsesRs & id_Rt_match_Rs) | (id_UsesRt & ex_Rt == id_Rt)) & !Flush.
  - id_Rt_match_Rs means ex_Rt == id_Rs.
  - LL (LLSC & MemRead) is treated as a load.
- Each rising edge uses this priority:
  1. Flush: ex_Valid <= 0 and ex_Ctrl <= 0. Data and fields are held. BubbleCount increments. Flush overrides ExStall.
  2. ExStall: all registers hold. No count.
  3. LoadUseStall: bubble as in (1), BubbleCount increments. ID is frozen through StallID.
  4. Otherwise: load every id_* input.
     - ex_Valid <= id_Valid.
     - If !id_Valid, ex_Ctrl <= 0.
     - Invalid instructions arriving from ID are not counted as bubbles.
- A bubble must have RegWrite = MemWrite = MemRead = Trap = 0; downstream stages rely on zeroed control alone.
- Latency: one cycle from ID to EX. A load-use hazard costs exactly one bubble; the next cycle the load has left EX, so the hazard clears.
- BubbleCount wraps modulo 2^CNTW without saturation.
- ExStall together with a load-use hazard: hold takes priority, StallID stays asserted, and the hazard is re-evaluated once ExStall drops.
- Reset asserted mid-stall or mid-flush: outputs clear immediately; no pending state survives.

Decomposition:
- Package pipeline_pkg holds:
  - typedef ex_ctrl_t, a packed struct of ALUOp[4:0], Link, ALUSrcImm, Trap, TrapCond, RegDst, LLSC, MemRead, MemWrite, MemHalf, MemByte, MemSignExtend, RegWrite, MemtoReg (18 bits);
  - constant EX_CTRL_NOP = '0;
  - constant REG_ZERO = 5'd0.
- One sub-module, load_use_detect, contains the purely combinational hazard compare. The register and counter stay in idex_stage_reg.

Test Plan:
- Reset mid-run: drive id_Valid=1, ALUOp=5'h0A, ReadData1=32'h1234; assert reset asynchronously between edges. All outputs read 0 immediately; after release, the next edge gives ex_Ctrl.ALUOp=5'h0A and ex_ReadData1=32'h1234.
- Load-use: EX holds LW with Rt=5'd8; ID has ADD with Rs=8, UsesRs=1. LoadUseStall=1 and StallID=1; next edge gives ex_Valid=0, ex_Ctrl=0, BubbleCount=1; following edge loads the ADD.
- No hazard: the same case with ex_Rt=0, or with id_UsesRt=0 and only Rt matching. LoadUseStall=0 and no bubble.
- ExStall held 3 cycles while ID inputs change. ex_* values are unchanged and BubbleCount is unchanged; the first edge after release loads the current ID inputs.
- Flush during ExStall with a load-use condition present. ex_Valid=0, ex_Ctrl=0, LoadUseStall=0; BubbleCount increments by exactly 1.
- Counter wrap: with CNTW=4, insert 17 bubbles. BubbleCount=1.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared types and constants for the MIPS III pipeline.
//   ex_ctrl_t   : decoded EX/MEM/WB control bundle carried from ID into EX (18 bits)
//   EX_CTRL_NOP : all-zero control word; a bubble carries exactly this
//   REG_ZERO    : architectural $zero specifier
package pipeline_pkg;

  typedef struct packed {
    logic [4:0] ALUOp;
    logic       Link;
    logic       ALUSrcImm;
    logic       Trap;
    logic       TrapCond;
    logic       RegDst;
    logic       LLSC;
    logic       MemRead;
    logic       MemWrite;
    logic       MemHalf;
    logic       MemByte;
    logic       MemSignExtend;
    logic       RegWrite;
    logic       MemtoReg;
  } ex_ctrl_t;

  localparam ex_ctrl_t   EX_CTRL_NOP = '0;
  localparam logic [4:0] REG_ZERO    = 5'd0;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard compare between the instruction in EX and the one in ID.
//   i_ex_valid, i_ex_mem_read, i_ex_rt : instruction in EX (LL counts as a load via MemRead)
//   i_id_valid, i_id_rs, i_id_rt       : instruction in ID
//   i_id_uses_rs, i_id_uses_rt         : ID actually reads that source
//   i_flush                            : ID instruction is being killed, so no stall
//   o_load_use                         : hazard this cycle
module load_use_detect
  import pipeline_pkg::*;
(
  input  logic       i_ex_valid,
  input  logic       i_ex_mem_read,
  input  logic [4:0] i_ex_rt,
  input  logic       i_id_valid,
  input  logic [4:0] i_id_rs,
  input  logic [4:0] i_id_rt,
  input  logic       i_id_uses_rs,
  input  logic       i_id_uses_rt,
  input  logic       i_flush,
  output logic       o_load_use
);

  logic w_ex_is_load;
  logic w_src_match;

  // A load targeting $zero never produces a value anyone waits for.
  assign w_ex_is_load = i_ex_valid & i_ex_mem_read & (i_ex_rt != REG_ZERO);
  assign w_src_match  = (i_id_uses_rs & (i_ex_rt == i_id_rs)) |
                        (i_id_uses_rt & (i_ex_rt == i_id_rt));
  assign o_load_use   = w_ex_is_load & i_id_valid & w_src_match & ~i_flush;

endmodule

// File: rtl/idex_stage_reg.sv
// ID/EX pipeline register.
//   clock, reset (async, active-high)
//   Flush, ExStall                      : bubble / hold controls
//   id_*                                : decoded instruction from ID
//   ex_*                                : registered instruction presented to EX
//   LoadUseStall, StallID               : combinational hazard / ID-freeze outputs
//   BubbleCount                         : bubbles inserted since reset (wraps)
module idex_stage_reg
  import pipeline_pkg::*;
#(
  parameter int unsigned DW   = 32,
  parameter int unsigned CNTW = 32
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            Flush,
  input  logic            ExStall,
  input  logic            id_Valid,
  input  ex_ctrl_t        id_Ctrl,
  input  logic [4:0]      id_Rs,
  input  logic [4:0]      id_Rt,
  input  logic [4:0]      id_Rd,
  input  logic            id_UsesRs,
  input  logic            id_UsesRt,
  input  logic [4:0]      id_Shamt,
  input  logic [DW-1:0]   id_ReadData1,
  input  logic [DW-1:0]   id_ReadData2,
  input  logic [DW-1:0]   id_ExtImmOut,
  input  logic [DW-1:0]   id_PC,
  output logic            ex_Valid,
  output ex_ctrl_t        ex_Ctrl,
  output logic [4:0]      ex_Rs,
  output logic [4:0]      ex_Rt,
  output logic [4:0]      ex_Rd,
  output logic [4:0]      ex_Shamt,
  output logic [DW-1:0]   ex_ReadData1,
  output logic [DW-1:0]   ex_ReadData2,
  output logic [DW-1:0]   ex_ExtImmOut,
  output logic [DW-1:0]   ex_PC,
  output logic            LoadUseStall,
  output logic            StallID,
  output logic [CNTW-1:0] BubbleCount
);

  logic            r_valid;
  ex_ctrl_t        r_ctrl;
  logic [4:0]      r_rs, r_rt, r_rd, r_shamt;
  logic [DW-1:0]   r_rd1, r_rd2, r_imm, r_pc;
  logic [CNTW-1:0] r_bubble_count;
  logic            w_load_use;

  load_use_detect u_load_use_detect (
    .i_ex_valid    (r_valid),
    .i_ex_mem_read (r_ctrl.MemRead),
    .i_ex_rt       (r_rt),
    .i_id_valid    (id_Valid),
    .i_id_rs       (id_Rs),
    .i_id_rt       (id_Rt),
    .i_id_uses_rs  (id_UsesRs),
    .i_id_uses_rt  (id_UsesRt),
    .i_flush       (Flush),
    .o_load_use    (w_load_use)
  );

  // Bubbles clear only valid/control; data fields are held since nothing downstream reads them.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_valid        <= 1'b0;
      r_ctrl         <= EX_CTRL_NOP;
      r_rs           <= '0;
      r_rt           <= '0;
      r_rd           <= '0;
      r_shamt        <= '0;
      r_rd1          <= '0;
      r_rd2          <= '0;
      r_imm          <= '0;
      r_pc           <= '0;
      r_bubble_count <= '0;
    end else if (Flush) begin
      r_valid        <= 1'b0;
      r_ctrl         <= EX_CTRL_NOP;
      r_bubble_count <= r_bubble_count + CNTW'(1);
    end else if (ExStall) begin
      // Hold everything; a pending hazard is re-evaluated when EX frees up.
    end else if (w_load_use) begin
      r_valid        <= 1'b0;
      r_ctrl         <= EX_CTRL_NOP;
      r_bubble_count <= r_bubble_count + CNTW'(1);
    end else begin
      r_valid <= id_Valid;
      r_ctrl  <= id_Valid ? id_Ctrl : EX_CTRL_NOP;
      r_rs    <= id_Rs;
      r_rt    <= id_Rt;
      r_rd    <= id_Rd;
      r_shamt <= id_Shamt;
      r_rd1   <= id_ReadData1;
      r_rd2   <= id_ReadData2;
      r_imm   <= id_ExtImmOut;
      r_pc    <= id_PC;
    end
  end

  assign ex_Valid     = r_valid;
  assign ex_Ctrl      = r_ctrl;
  assign ex_Rs        = r_rs;
  assign ex_Rt        = r_rt;
  assign ex_Rd        = r_rd;
  assign ex_Shamt     = r_shamt;
  assign ex_ReadData1 = r_rd1;
  assign ex_ReadData2 = r_rd2;
  assign ex_ExtImmOut = r_imm;
  assign ex_PC        = r_pc;
  assign LoadUseStall = w_load_use;
  assign StallID      = w_load_use | ExStall;
  assign BubbleCount  = r_bubble_count;

endmodule

// File: tb/tb_idex_stage_reg.sv
module tb_idex_stage_reg;
  import pipeline_pkg::*;

  localparam int unsigned DW = 32;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic          Flush, ExStall, id_Valid, id_UsesRs, id_UsesRt;
  ex_ctrl_t      id_Ctrl;
  logic [4:0]    id_Rs, id_Rt, id_Rd, id_Shamt;
  logic [DW-1:0] id_ReadData1, id_ReadData2, id_ExtImmOut, id_PC;

  logic          ex_Valid, LoadUseStall, StallID;
  ex_ctrl_t      ex_Ctrl;
  logic [4:0]    ex_Rs, ex_Rt, ex_Rd, ex_Shamt;
  logic [DW-1:0] ex_ReadData1, ex_ReadData2, ex_ExtImmOut, ex_PC;
  logic [31:0]   BubbleCount;

  logic          ex_Valid4, LoadUseStall4, StallID4;
  ex_ctrl_t      ex_Ctrl4;
  logic [4:0]    ex_Rs4, ex_Rt4, ex_Rd4, ex_Shamt4;
  logic [DW-1:0] ex_ReadData14, ex_ReadData24, ex_ExtImmOut4, ex_PC4;
  logic [3:0]    BubbleCount4;

  idex_stage_reg #(.DW(DW), .CNTW(32)) dut (
    .clock(clock), .reset(reset), .Flush(Flush), .ExStall(ExStall), .id_Valid(id_Valid),
    .id_Ctrl(id_Ctrl), .id_Rs(id_Rs), .id_Rt(id_Rt), .id_Rd(id_Rd), .id_UsesRs(id_UsesRs),
    .id_UsesRt(id_UsesRt), .id_Shamt(id_Shamt), .id_ReadData1(id_ReadData1),
    .id_ReadData2(id_ReadData2), .id_ExtImmOut(id_ExtImmOut), .id_PC(id_PC),
    .ex_Valid(ex_Valid), .ex_Ctrl(ex_Ctrl), .ex_Rs(ex_Rs), .ex_Rt(ex_Rt), .ex_Rd(ex_Rd),
    .ex_Shamt(ex_Shamt), .ex_ReadData1(ex_ReadData1), .ex_ReadData2(ex_ReadData2),
    .ex_ExtImmOut(ex_ExtImmOut), .ex_PC(ex_PC), .LoadUseStall(LoadUseStall),
    .StallID(StallID), .BubbleCount(BubbleCount)
  );

  // Narrow-counter instance, same stimulus, used for wrap checking.
  idex_stage_reg #(.DW(DW), .CNTW(4)) dut4 (
    .clock(clock), .reset(reset), .Flush(Flush), .ExStall(ExStall), .id_Valid(id_Valid),
    .id_Ctrl(id_Ctrl), .id_Rs(id_Rs), .id_Rt(id_Rt), .id_Rd(id_Rd), .id_UsesRs(id_UsesRs),
    .id_UsesRt(id_UsesRt), .id_Shamt(id_Shamt), .id_ReadData1(id_ReadData1),
    .id_ReadData2(id_ReadData2), .id_ExtImmOut(id_ExtImmOut), .id_PC(id_PC),
    .ex_Valid(ex_Valid4), .ex_Ctrl(ex_Ctrl4), .ex_Rs(ex_Rs4), .ex_Rt(ex_Rt4), .ex_Rd(ex_Rd4),
    .ex_Shamt(ex_Shamt4), .ex_ReadData1(ex_ReadData14), .ex_ReadData2(ex_ReadData24),
    .ex_ExtImmOut(ex_ExtImmOut4), .ex_PC(ex_PC4), .LoadUseStall(LoadUseStall4),
    .StallID(StallID4), .BubbleCount(BubbleCount4)
  );

  int errs = 0;
  int checks = 0;

  // Reference model: what EX is holding, plus the running bubble tally.
  logic          m_valid;
  ex_ctrl_t      m_ctrl;
  logic [4:0]    m_rs, m_rt, m_rd, m_sh;
  logic [DW-1:0] m_rd1, m_rd2, m_imm, m_pc;
  logic [31:0]   m_cnt;

  wire [198:0] dut_vec = {ex_Valid, ex_Ctrl, ex_Rs, ex_Rt, ex_Rd, ex_Shamt, ex_ReadData1,
                          ex_ReadData2, ex_ExtImmOut, ex_PC, BubbleCount};

  function automatic logic [198:0] exp_vec();
    return {m_valid, m_ctrl, m_rs, m_rt, m_rd, m_sh, m_rd1, m_rd2, m_imm, m_pc, m_cnt};
  endfunction

  // EX holds a real load writing a nonzero register that the live ID instruction reads.
  function automatic logic m_hazard();
    logic reads_it;
    reads_it = (id_UsesRs && m_rt == id_Rs) || (id_UsesRt && m_rt == id_Rt);
    return m_valid && m_ctrl.MemRead && m_rt != 5'd0 && id_Valid && reads_it && !Flush;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0; m_ctrl = '0; m_rs = '0; m_rt = '0; m_rd = '0; m_sh = '0;
    m_rd1 = '0; m_rd2 = '0; m_imm = '0; m_pc = '0; m_cnt = '0;
  endtask

  task automatic tick();
    logic hz;
    hz = m_hazard();
    @(posedge clock);
    if (reset) model_reset();
    else if (Flush || (!ExStall && hz)) begin
      m_valid = 1'b0; m_ctrl = '0; m_cnt = m_cnt + 32'd1;
    end else if (!ExStall) begin
      m_valid = id_Valid; m_ctrl = id_Valid ? id_Ctrl : '0;
      m_rs = id_Rs; m_rt = id_Rt; m_rd = id_Rd; m_sh = id_Shamt;
      m_rd1 = id_ReadData1; m_rd2 = id_ReadData2; m_imm = id_ExtImmOut; m_pc = id_PC;
    end
    #1;
  endtask

  task automatic drive_idle();
    Flush = 0; ExStall = 0; id_Valid = 0; id_Ctrl = '0; id_Rs = 0; id_Rt = 0; id_Rd = 0;
    id_UsesRs = 0; id_UsesRt = 0; id_Shamt = 0;
    id_ReadData1 = 0; id_ReadData2 = 0; id_ExtImmOut = 0; id_PC = 0;
  endtask

  function automatic ex_ctrl_t lw_ctrl();
    ex_ctrl_t c = '0;
    c.MemRead = 1; c.RegWrite = 1; c.MemtoReg = 1; c.ALUSrcImm = 1;
    return c;
  endfunction

  function automatic ex_ctrl_t add_ctrl();
    ex_ctrl_t c = '0;
    c.ALUOp = 5'h02; c.RegWrite = 1; c.RegDst = 1;
    return c;
  endfunction

  task automatic load_lw(input logic [4:0] rt);
    drive_idle();
    id_Valid = 1; id_Ctrl = lw_ctrl(); id_Rs = 5'd29; id_Rt = rt; id_UsesRs = 1;
    id_ExtImmOut = 32'h10; id_PC = 32'h400;
    tick();
  endtask

  task automatic test_reset();
    drive_idle();
    #1 reset = 1;
    #1;
    checks++;
    if (dut_vec !== '0 || BubbleCount4 !== 4'd0) begin
      errs++; $display("FAIL reset_init: got %h want 0", dut_vec);
    end
    model_reset();
    id_Valid = 1; id_Ctrl.ALUOp = 5'h0A; id_ReadData1 = 32'h1234;
    @(negedge clock) reset = 0;
    tick();
    checks++;
    if (ex_Ctrl.ALUOp !== 5'h0A || dut_vec !== exp_vec()) begin
      errs++; $display("FAIL reset_first_load: got %h want %h", dut_vec, exp_vec());
    end
    #2 reset = 1;
    #1;
    checks++;
    if (dut_vec !== '0 || ex_Valid !== 1'b0) begin
      errs++; $display("FAIL reset_async: got %h want 0", dut_vec);
    end
    model_reset();
    #1 reset = 0;
    tick();
    checks++;
    if (ex_Ctrl.ALUOp !== 5'h0A || ex_ReadData1 !== 32'h1234 || ex_Valid !== 1'b1 ||
        dut_vec !== exp_vec()) begin
      errs++; $display("FAIL reset_release: got %h want %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_load_use();
    load_lw(5'd8);
    id_Ctrl = add_ctrl(); id_Rs = 5'd8; id_Rt = 5'd9; id_Rd = 5'd10; id_UsesRs = 1;
    id_UsesRt = 1; id_ReadData1 = 32'hAAAA; id_PC = 32'h404;
    #1;
    checks++;
    if (LoadUseStall !== 1'b1 || StallID !== 1'b1) begin
      errs++; $display("FAIL lu_detect: got %b%b want 11", LoadUseStall, StallID);
    end
    tick();
    checks++;
    if (ex_Valid !== 0 || ex_Ctrl !== '0 || BubbleCount !== 32'd1 || dut_vec !== exp_vec()) begin
      errs++; $display("FAIL lu_bubble: got %h want %h", dut_vec, exp_vec());
    end
    checks++;
    if (LoadUseStall !== 1'b0) begin
      errs++; $display("FAIL lu_clears: got %b want 0", LoadUseStall);
    end
    tick();
    checks++;
    if (ex_Valid !== 1 || ex_Rs !== 5'd8 || ex_Ctrl !== add_ctrl() || dut_vec !== exp_vec()) begin
      errs++; $display("FAIL lu_follow: got %h want %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_no_hazard();
    logic [31:0] c0;
    load_lw(5'd0);
    id_Ctrl = add_ctrl(); id_Rs = 5'd0; id_Rt = 5'd0; id_UsesRs = 1; id_UsesRt = 1;
    #1;
    checks++;
    if (LoadUseStall !== 1'b0) begin
      errs++; $display("FAIL nohz_zero_rt: got %b want 0", LoadUseStall);
    end
    load_lw(5'd8);
    c0 = m_cnt;
    id_Ctrl = add_ctrl(); id_Rs = 5'd3; id_Rt = 5'd8; id_UsesRs = 1; id_UsesRt = 0;
    #1;
    checks++;
    if (LoadUseStall !== 1'b0 || StallID !== 1'b0) begin
      errs++; $display("FAIL nohz_rt_unused: got %b%b want 00", LoadUseStall, StallID);
    end
    tick();
    checks++;
    if (ex_Valid !== 1 || BubbleCount !== c0 || dut_vec !== exp_vec()) begin
      errs++; $display("FAIL nohz_load: got %h want %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_ex_stall();
    logic [198:0] snap;
    drive_idle();
    id_Valid = 1; id_Ctrl = add_ctrl(); id_Rs = 5'd4; id_ReadData1 = 32'h55;
    tick();
    snap = exp_vec();
    ExStall = 1;
    for (int i = 0; i < 3; i++) begin
      id_Rs = 5'($urandom); id_Rt = 5'($urandom); id_ReadData1 = $urandom;
      id_ReadData2 = $urandom; id_PC = $urandom;
      #1;
      checks++;
      if (StallID !== 1'b1) begin
        errs++; $display("FAIL stall_stallid: got %b want 1", StallID);
      end
      tick();
      checks++;
      if (dut_vec !== snap) begin
        errs++; $display("FAIL stall_hold[%0d]: got %h want %h", i, dut_vec, snap);
      end
    end
    ExStall = 0;
    tick();
    checks++;
    if (ex_ReadData1 !== id_ReadData1 || ex_PC !== id_PC || ex_Rs !== id_Rs ||
        dut_vec !== exp_vec()) begin
      errs++; $display("FAIL stall_release: got %h want %h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_flush_during_stall();
    logic [31:0] c0;
    load_lw(5'd8);
    c0 = m_cnt;
    id_Ctrl = add_ctrl(); id_Rs = 5'd8; id_UsesRs = 1; ExStall = 1;
    #1;
    checks++;
    if (LoadUseStall !== 1'b1 || StallID !== 1'b1) begin
      errs++; $display("FAIL stall_lu_both: got %b%b want 11", LoadUseStall, StallID);
    end
    tick();
    checks++;
    if (ex_Valid !== 1'b1 || BubbleCount !== c0) begin
      errs++; $display("FAIL stall_lu_hold: got %h want %h", dut_vec, exp_vec());
    end
    Flush = 1;
    #1;
    checks++;
    if (LoadUseStall !== 1'b0) begin
      errs++; $display("FAIL flush_masks_lu: got %b want 0", LoadUseStall);
    end
    tick();
    checks++;
    if (ex_Valid !== 0 || ex_Ctrl !== '0 || BubbleCount !== c0 + 32'd1 || ex_Rt !== 5'd8 ||
        dut_vec !== exp_vec()) begin
      errs++; $display("FAIL flush_stall: got %h want %h", dut_vec, exp_vec());
    end
    drive_idle();
  endtask

  task automatic test_wrap();
    drive_idle();
    reset = 1;
    #1 reset = 0;
    model_reset();
    Flush = 1;
    repeat (17) tick();
    checks++;
    if (BubbleCount4 !== 4'd1 || BubbleCount !== 32'd17) begin
      errs++; $display("FAIL wrap: got %0d/%0d want 1/17", BubbleCount4, BubbleCount);
    end
    drive_idle();
  endtask

  task automatic test_random();
    logic [31:0] r;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 63) == 0) begin
        reset = 1;
        #1;
        checks++;
        if (dut_vec !== '0 || BubbleCount4 !== 4'd0) begin
          errs++; $display("FAIL rnd_reset[%0d]: got %h want 0", i, dut_vec);
        end
        model_reset();
        reset = 0;
      end
      r = $urandom;
      Flush = ($urandom_range(0, 7) == 0);
      ExStall = ($urandom_range(0, 3) == 0);
      id_Valid = ($urandom_range(0, 4) != 0);
      id_Ctrl = r[17:0];
      if ($urandom_range(0, 1) == 1) id_Ctrl.MemRead = 1;
      id_Rs = 5'($urandom_range(0, 3)); id_Rt = 5'($urandom_range(0, 3));
      id_Rd = 5'($urandom); id_Shamt = 5'($urandom);
      id_UsesRs = 1'($urandom); id_UsesRt = 1'($urandom);
      id_ReadData1 = $urandom; id_ReadData2 = $urandom; id_ExtImmOut = $urandom; id_PC = $urandom;
      #1;
      checks++;
      if (LoadUseStall !== m_hazard() || StallID !== (m_hazard() || ExStall)) begin
        errs++; $display("FAIL rnd_hazard[%0d]: got %b%b want %b%b", i, LoadUseStall, StallID,
                         m_hazard(), m_hazard() || ExStall);
      end
      tick();
      checks++;
      if (dut_vec !== exp_vec() || BubbleCount4 !== m_cnt[3:0]) begin
        errs++; $display("FAIL rnd_state[%0d]: got %h want %h", i, dut_vec, exp_vec());
      end
    end
    drive_idle();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_load_use();
    test_no_hazard();
    test_ex_stall();
    test_flush_during_stall();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
